rmii_frame_tx: RTL

- RMII transmit framer: takes frame payload bytes over a valid/ready byte stream and emits a complete 802.3 frame as dibits on the RMII TX pins.
- Inserts the preamble and SFD, pads short frames, appends the FCS and enforces the inter-frame gap.
- Sits between the MAC TX buffer logic and the PHY. It is also used in benches as the stimulus source for the MAC receive path, replacing random dibit generation.
- Runs on the 50 MHz RMII reference clock, 100 Mb/s only: one dibit per cycle.

---
 rtl/eth_pkg.sv | 27 ++
 rtl/eth_crc32_d2.sv | 23 ++
 rtl/rmii_frame_tx.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_pkg
// Description : Shared Ethernet framing constants and the TX framer state type.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_pkg;

    // Preamble length in dibits, before the four SFD dibits
    localparam int          PREAMBLE_DIBITS = 28;
    // Start-of-frame delimiter, sent LSB dibit first
    localparam logic [7:0]  SFD             = 8'hD5;
    // 802.3 CRC-32, reflected form
    localparam logic [31:0] CRC_POLY        = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT        = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_DATA = 3'd2,
        ST_PAD  = 3'd3,
        ST_FCS  = 3'd4,
        ST_IFG  = 3'd5
    } tx_state_t;

endpackage : eth_pkg
`default_nettype wire

// File: rtl/eth_crc32_d2.sv
`default_nettype none
// ============================================================================
// Module      : eth_crc32_d2
// Description : Combinational CRC-32 next state for one 2-bit symbol,
//               d_i[0] is the earlier bit on the wire.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_crc32_d2
    import eth_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [1:0]  d_i,
    output logic [31:0] crc_o
);

    logic [31:0] w_stage1;

    // Two serial steps of the reflected LFSR, first bit d_i[0]
    assign w_stage1 = {1'b0, crc_i[31:1]}    ^ ((crc_i[0]    ^ d_i[0]) ? CRC_POLY : 32'h0);
    assign crc_o    = {1'b0, w_stage1[31:1]} ^ ((w_stage1[0] ^ d_i[1]) ? CRC_POLY : 32'h0);

endmodule : eth_crc32_d2
`default_nettype wire

// File: rtl/rmii_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : rmii_frame_tx
// Description : RMII 100 Mb/s transmit framer. Adds preamble/SFD, pads short
//               frames, appends the FCS and enforces the inter-frame gap.
//               Registered state describes the dibit currently on the wire.
// Revision    : 1.0 - initial release
// ============================================================================
module rmii_frame_tx
    import eth_pkg::*;
#(
    parameter int MIN_LEN   = 60,
    parameter int PAD_EN    = 1,
    parameter int IFG_BYTES = 12
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  tx_dat_i,
    input  logic        tx_valid_i,
    input  logic        tx_last_i,
    output logic        tx_ready_o,
    output logic        phy_tx_en,
    output logic [1:0]  phy_rmii_tx_data,
    output logic        busy_o,
    output logic        underrun_o,
    output logic [15:0] frames_o
);

    localparam logic [15:0] c_MIN_LEN  = 16'(MIN_LEN);
    localparam logic [15:0] c_IFG_LAST = 16'(IFG_BYTES * 4 - 1);
    localparam logic [15:0] c_PRE_LEN  = 16'(PREAMBLE_DIBITS);
    localparam logic [15:0] c_PRE_LAST = 16'(PREAMBLE_DIBITS + 3);
    localparam logic [15:0] c_FCS_LAST = 16'd15;

    tx_state_t   r_state, w_state_n;
    logic [15:0] r_cnt, w_cnt_n;
    logic [1:0]  r_idx, w_idx_n;
    logic [7:0]  r_byte, w_byte_n;
    logic        r_last, w_last_n;
    logic        r_bad, w_bad_n;
    logic [31:0] r_crc, w_crc_n;
    logic [15:0] r_bcnt, w_bcnt_n;
    logic [15:0] r_frames, w_frames_n;
    logic        r_under, w_under_n;
    logic        r_tx_en, w_tx_en_n;
    logic [1:0]  r_txd, w_txd_n;
    logic        r_ready, w_ready_n;
    logic        r_busy;
    logic [31:0] w_crc_upd;
    logic [15:0] w_bcnt_inc;
    logic [1:0]  w_fcs_dibit;

    // CRC advanced by the dibit currently on the wire
    eth_crc32_d2 u_crc (
        .crc_i (r_crc),
        .d_i   (r_txd),
        .crc_o (w_crc_upd)
    );

    assign w_bcnt_inc = (r_bcnt == 16'hFFFF) ? r_bcnt : r_bcnt + 16'd1;

    // Next-state logic for the framer sequence
    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_idx_n    = r_idx;
        w_byte_n   = r_byte;
        w_last_n   = r_last;
        w_bad_n    = r_bad;
        w_crc_n    = r_crc;
        w_bcnt_n   = r_bcnt;
        w_frames_n = r_frames;
        w_under_n  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (tx_valid_i) begin
                    w_state_n = ST_PRE;
                    w_cnt_n   = 16'd0;
                end
            end
            ST_PRE: begin
                if (r_cnt == c_PRE_LAST) begin
                    w_crc_n  = CRC_INIT;
                    w_bcnt_n = 16'd0;
                    w_idx_n  = 2'd0;
                    w_bad_n  = 1'b0;
                    if (tx_valid_i) begin
                        w_state_n = ST_DATA;
                        w_byte_n  = tx_dat_i;
                        w_last_n  = tx_last_i;
                    end else begin
                        // Nothing to send after SFD: close with a bad FCS
                        w_state_n = ST_FCS;
                        w_cnt_n   = 16'd0;
                        w_bad_n   = 1'b1;
                        w_under_n = 1'b1;
                    end
                end else begin
                    w_cnt_n = r_cnt + 16'd1;
                end
            end
            ST_DATA: begin
                w_crc_n = w_crc_upd;
                w_idx_n = r_idx + 2'd1;
                if (r_idx == 2'd3) begin
                    w_bcnt_n = w_bcnt_inc;
                    if (r_last) begin
                        if ((PAD_EN != 0) && (w_bcnt_inc < c_MIN_LEN)) begin
                            w_state_n = ST_PAD;
                            w_byte_n  = 8'h00;
                        end else begin
                            w_state_n = ST_FCS;
                            w_cnt_n   = 16'd0;
                        end
                    end else if (tx_valid_i) begin
                        w_byte_n = tx_dat_i;
                        w_last_n = tx_last_i;
                    end else begin
                        w_state_n = ST_FCS;
                        w_cnt_n   = 16'd0;
                        w_bad_n   = 1'b1;
                        w_under_n = 1'b1;
                    end
                end
            end
            ST_PAD: begin
                w_crc_n = w_crc_upd;
                w_idx_n = r_idx + 2'd1;
                if (r_idx == 2'd3) begin
                    w_bcnt_n = w_bcnt_inc;
                    if (w_bcnt_inc >= c_MIN_LEN) begin
                        w_state_n = ST_FCS;
                        w_cnt_n   = 16'd0;
                    end
                end
            end
            ST_FCS: begin
                if (r_cnt == c_FCS_LAST) begin
                    w_state_n = ST_IFG;
                    w_cnt_n   = 16'd0;
                    if (!r_bad) begin
                        w_frames_n = r_frames + 16'd1;
                    end
                end else begin
                    w_cnt_n = r_cnt + 16'd1;
                end
            end
            ST_IFG: begin
                if (r_cnt == c_IFG_LAST) begin
                    w_state_n = ST_IDLE;
                end else begin
                    w_cnt_n = r_cnt + 16'd1;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    // Wire values for the next cycle, decoded from the next state
    always_comb begin
        w_tx_en_n   = 1'b0;
        w_txd_n     = 2'b00;
        w_ready_n   = 1'b0;
        w_fcs_dibit = w_crc_n[{w_cnt_n[3:0], 1'b0} +: 2];
        case (w_state_n)
            ST_PRE: begin
                w_tx_en_n = 1'b1;
                w_txd_n   = (w_cnt_n < c_PRE_LEN) ? 2'b01 : SFD[{w_cnt_n[1:0], 1'b0} +: 2];
                w_ready_n = (w_cnt_n == c_PRE_LAST);
            end
            ST_DATA: begin
                w_tx_en_n = 1'b1;
                w_txd_n   = w_byte_n[{w_idx_n, 1'b0} +: 2];
                w_ready_n = (w_idx_n == 2'd3) && !w_last_n;
            end
            ST_PAD: begin
                w_tx_en_n = 1'b1;
                w_txd_n   = w_byte_n[{w_idx_n, 1'b0} +: 2];
            end
            ST_FCS: begin
                w_tx_en_n = 1'b1;
                w_txd_n   = w_bad_n ? w_fcs_dibit : ~w_fcs_dibit;
            end
            default: begin
                w_tx_en_n = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 16'd0;
            r_idx    <= 2'd0;
            r_byte   <= 8'h00;
            r_last   <= 1'b0;
            r_bad    <= 1'b0;
            r_crc    <= 32'h0;
            r_bcnt   <= 16'd0;
            r_frames <= 16'd0;
            r_under  <= 1'b0;
            r_tx_en  <= 1'b0;
            r_txd    <= 2'b00;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_idx    <= w_idx_n;
            r_byte   <= w_byte_n;
            r_last   <= w_last_n;
            r_bad    <= w_bad_n;
            r_crc    <= w_crc_n;
            r_bcnt   <= w_bcnt_n;
            r_frames <= w_frames_n;
            r_under  <= w_under_n;
            r_tx_en  <= w_tx_en_n;
            r_txd    <= w_txd_n;
            r_ready  <= w_ready_n;
            r_busy   <= (w_state_n != ST_IDLE);
        end
    end

    assign tx_ready_o       = r_ready;
    assign phy_tx_en        = r_tx_en;
    assign phy_rmii_tx_data = r_txd;
    assign busy_o           = r_busy;
    assign underrun_o       = r_under;
    assign frames_o         = r_frames;

endmodule : rmii_frame_tx
`default_nettype wire
